// File: rtl/io_bank.sv
// Memory-mapped board I/O bank: LEDs, seven-segment digits, LCD word and debounced switches.
// Define IO_HEX_DECODE_EN to store 5-bit hex nibbles (bit 4 = blank) instead of raw segments.
module io_bank #(
    parameter int unsigned NUM_HEX      = 8,
    parameter int unsigned LEDR_W       = 32,
    parameter int unsigned LEDG_W       = 32,
    parameter int unsigned SW_W         = 32,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [11:0]          addr_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 ack_o,
    output logic                 err_o,
    input  logic [SW_W-1:0]      io_sw_i,
    output logic [LEDR_W-1:0]    ledr_o,
    output logic [LEDG_W-1:0]    ledg_o,
    output logic [7*NUM_HEX-1:0] hex_o,
    output logic [31:0]          io_lcd_o,
    output logic                 sw_change_o
);

`ifdef IO_HEX_DECODE_EN
    localparam int unsigned HEX_W = 5;
    localparam logic [HEX_W-1:0] HEX_RST = 5'h10;
`else
    localparam int unsigned HEX_W = 7;
    localparam logic [HEX_W-1:0] HEX_RST = 7'h7F;
`endif
    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [LEDR_W-1:0] ledr_q;
    logic [LEDG_W-1:0] ledg_q;
    logic [31:0]       lcd_q;
    logic [HEX_W-1:0]  hex_q [NUM_HEX];
    logic [31:0]       rdata_q;
    logic              ack_q, err_q;

    logic [SW_W-1:0]   sw_s1_q, sw_s2_q, sw_cand_q, sw_db_q;
    logic [CNT_W-1:0]  sw_cnt_q;
    logic              sw_change_q;

    logic        sel_ledr, sel_ledg, sel_lcd, sel_sw, sel_hex;
    logic [3:0]  hex_idx;
    logic [31:0] rd_val;
    logic        acc_err;
    logic        wr_en;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = be[k] ? wd[8*k +: 8] : old[8*k +: 8];
        end
        return r;
    endfunction

`ifdef IO_HEX_DECODE_EN
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction
`endif

    always_comb begin
        sel_ledr = (addr_i == 12'h000);
        sel_ledg = (addr_i == 12'h010);
        sel_lcd  = (addr_i == 12'h030);
        sel_sw   = (addr_i == 12'h800);
        sel_hex  = (addr_i[11:8] == 4'h1) && (addr_i[1:0] == 2'b00) &&
                   ({26'd0, addr_i[7:2]} < NUM_HEX);
        hex_idx  = addr_i[5:2];
        rd_val   = '0;
        if (sel_ledr) rd_val = 32'(ledr_q);
        if (sel_ledg) rd_val = 32'(ledg_q);
        if (sel_lcd)  rd_val = lcd_q;
        if (sel_sw)   rd_val = 32'(sw_db_q);
        for (int i = 0; i < NUM_HEX; i++) begin
            if (sel_hex && hex_idx == 4'(i)) rd_val = 32'(hex_q[i]);
        end
        // Unmapped/misaligned addresses fail every select; SW is read-only.
        acc_err = !(sel_ledr || sel_ledg || sel_lcd || sel_sw || sel_hex) || (we_i && sel_sw);
        wr_en   = req_i && we_i && !acc_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            lcd_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= HEX_RST;
        end else begin
            ack_q   <= req_i;
            err_q   <= req_i && acc_err;
            rdata_q <= (req_i && !we_i && !acc_err) ? rd_val : '0;
            if (wr_en) begin
                if (sel_ledr) ledr_q <= LEDR_W'(merge(32'(ledr_q), wdata_i, be_i));
                if (sel_ledg) ledg_q <= LEDG_W'(merge(32'(ledg_q), wdata_i, be_i));
                if (sel_lcd)  lcd_q  <= merge(lcd_q, wdata_i, be_i);
                for (int i = 0; i < NUM_HEX; i++) begin
                    if (sel_hex && hex_idx == 4'(i)) begin
                        hex_q[i] <= HEX_W'(merge(32'(hex_q[i]), wdata_i, be_i));
                    end
                end
            end
        end
    end

    // Candidate must match the synchronised input for DEBOUNCE_CYC consecutive checks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_cand_q   <= '0;
            sw_db_q     <= '0;
            sw_cnt_q    <= '0;
            sw_change_q <= 1'b0;
        end else begin
            sw_s1_q     <= io_sw_i;
            sw_s2_q     <= sw_s1_q;
            sw_change_q <= 1'b0;
            if (sw_s2_q != sw_cand_q) begin
                sw_cand_q <= sw_s2_q;
                sw_cnt_q  <= '0;
            end else if (sw_cnt_q == CNT_MAX) begin
                sw_db_q     <= sw_cand_q;
                sw_change_q <= (sw_cand_q != sw_db_q);
            end else begin
                sw_cnt_q <= sw_cnt_q + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
`ifdef IO_HEX_DECODE_EN
        assign hex_o[7*g +: 7] = hex_q[g][4] ? 7'h7F : seg_decode(hex_q[g][3:0]);
`else
        assign hex_o[7*g +: 7] = hex_q[g];
`endif
    end

    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign ledr_o      = ledr_q;
    assign ledg_o      = ledg_q;
    assign io_lcd_o    = lcd_q;
    assign sw_change_o = sw_change_q;

endmodule

// File: tb/tb_io_bank.sv
// Scoreboard bench for io_bank: bus responses queued at issue and popped on ack_o,
// pins and the debounced switch path compared against a behavioural model every cycle.
module tb_io_bank;
    localparam int unsigned NUM_HEX = 8;
    localparam int unsigned LEDR_W  = 32;
    localparam int unsigned LEDG_W  = 32;
    localparam int unsigned SW_W    = 32;
    localparam int unsigned DB      = 4;
`ifdef IO_HEX_DECODE_EN
    localparam int unsigned HEX_W   = 5;
    localparam logic [31:0] HEX_RST = 32'h10;
`else
    localparam int unsigned HEX_W   = 7;
    localparam logic [31:0] HEX_RST = 32'h7F;
`endif

    logic                 clk, rst, req, we;
    logic [11:0]          addr;
    logic [3:0]           be;
    logic [31:0]          wdata, rdata;
    logic                 ack, err, sw_change;
    logic [SW_W-1:0]      io_sw;
    logic [LEDR_W-1:0]    ledr;
    logic [LEDG_W-1:0]    ledg;
    logic [7*NUM_HEX-1:0] hex;
    logic [31:0]          lcd;

    io_bank #(
        .NUM_HEX(NUM_HEX), .LEDR_W(LEDR_W), .LEDG_W(LEDG_W), .SW_W(SW_W), .DEBOUNCE_CYC(DB)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .err_o(err), .io_sw_i(io_sw),
        .ledr_o(ledr), .ledg_o(ledg), .hex_o(hex), .io_lcd_o(lcd), .sw_change_o(sw_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_ledr, m_ledg, m_lcd, m_sw_db;
    logic [31:0] m_hex [NUM_HEX];
    logic        m_change;
    logic [31:0] hist[$];
    bit          stable;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [6:0] hex_pin(input logic [31:0] v);
`ifdef IO_HEX_DECODE_EN
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return v[4] ? 7'h7F : tbl[v[3:0]];
`else
        return v[6:0];
`endif
    endfunction

    function automatic logic [63:0] exp_hex();
        logic [63:0] r = '0;
        for (int i = 0; i < NUM_HEX; i++) r[7*i +: 7] = hex_pin(m_hex[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_ledr = '0;
        m_ledg = '0;
        m_lcd  = '0;
        for (int i = 0; i < NUM_HEX; i++) m_hex[i] = HEX_RST;
    endtask

    // Debounced value: the input sampled two edges ago, once it and the DB samples before it agree.
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            for (int i = 0; i < DB + 3; i++) hist.push_back(32'd0);
            m_sw_db  = '0;
            m_change = 1'b0;
        end else begin
            hist.push_back(32'(io_sw));
            if (hist.size() > DB + 3) void'(hist.pop_front());
            stable = 1'b1;
            for (int i = 1; i <= DB; i++) if (hist[i] != hist[0]) stable = 1'b0;
            m_change = stable && (hist[DB] != m_sw_db);
            if (stable) m_sw_db = hist[DB];
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        check("ack", {63'd0, ack}, {63'd0, exp_q.size() > 0});
        if (ack && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("err", {63'd0, err}, {63'd0, e.err});
            if (e.is_read) check("rdata", {32'd0, rdata}, {32'd0, e.rdata});
        end
        check("ledr", 64'(ledr), 64'(m_ledr));
        check("ledg", 64'(ledg), 64'(m_ledg));
        check("lcd", 64'(lcd), 64'(m_lcd));
        check("hex", 64'(hex), exp_hex());
        check("sw_change", {63'd0, sw_change}, {63'd0, m_change});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
            we  = 1'b0;
        end
    endtask

    task automatic access(input bit w, input logic [11:0] a, input logic [3:0] b,
                          input logic [31:0] d);
        exp_t        e;
        int          kind;
        logic [31:0] cur, nv;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        if (a == 12'h000) kind = 0;
        else if (a == 12'h010) kind = 1;
        else if (a == 12'h030) kind = 2;
        else if (a == 12'h800) kind = 4;
        else if (a >= 12'h100 && 32'(a) < 32'h100 + 4 * NUM_HEX && a[1:0] == 2'b00) kind = 3;
        else kind = 5;
        case (kind)
            0: cur = m_ledr;
            1: cur = m_ledg;
            2: cur = m_lcd;
            3: cur = m_hex[(32'(a) - 32'h100) / 4];
            4: cur = m_sw_db;
            default: cur = '0;
        endcase
        e.is_read = !w;
        e.rdata   = '0;
        e.err     = (kind == 5) || (kind == 4 && w);
        if (!e.err && !w) e.rdata = cur;
        if (!e.err && w) begin
            nv = cur;
            for (int k = 0; k < 4; k++) if (b[k]) nv[8*k +: 8] = d[8*k +: 8];
            case (kind)
                0: m_ledr = nv & wmask(LEDR_W);
                1: m_ledg = nv & wmask(LEDG_W);
                2: m_lcd  = nv;
                default: m_hex[(32'(a) - 32'h100) / 4] = nv & wmask(HEX_W);
            endcase
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom % 8)
            0: return 12'h000;
            1: return 12'h010;
            2: return 12'h030;
            3: return 12'h800;
            4, 5: return 12'(32'h100 + 4 * $urandom_range(0, NUM_HEX - 1));
            6: return 12'(32'h100 + 4 * $urandom_range(0, 15));
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; io_sw = '0;
        model_reset();
        idle(3);
        rst = 1'b0;

        access(0, 12'h000, 4'hF, 0);
        access(0, 12'h010, 4'hF, 0);
        access(0, 12'h030, 4'hF, 0);
        for (int i = 0; i < NUM_HEX; i++) access(0, 12'(32'h100 + 4 * i), 4'hF, 0);
        access(0, 12'h800, 4'hF, 0);

        access(1, 12'h000, 4'b0101, 32'hDEAD_BEEF);
        access(0, 12'h000, 4'hF, 0);
        access(1, 12'h004, 4'hF, 32'h1234_5678);
        access(0, 12'h7FC, 4'hF, 0);
        access(1, 12'h102, 4'hF, 32'hFFFF_FFFF);
        access(0, 12'h102, 4'hF, 0);
        access(1, 12'h800, 4'hF, 32'h0000_00FF);
        access(0, 12'h800, 4'hF, 0);
        access(1, 12'h108, 4'h1, 32'h0000_0003);
        access(0, 12'h108, 4'hF, 0);
        access(1, 12'h108, 4'h1, 32'h0000_0010);
        access(1, 12'h108, 4'h1, 32'h0000_0012);
        access(1, 12'h030, 4'b1010, 32'hA5A5_5A5A);
        access(0, 12'h030, 4'hF, 0);

        io_sw = 32'h5;
        for (int i = 0; i < 10; i++) access(0, 12'h800, 4'hF, 0);
        io_sw = 32'h0;
        idle(10);
        io_sw = 32'h5;
        for (int i = 0; i < 3; i++) access(0, 12'h800, 4'hF, 0);
        io_sw = 32'h0;
        for (int i = 0; i < 10; i++) access(0, 12'h800, 4'hF, 0);

        io_sw = 32'hA;
        idle(4);
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 12'h000; be = 4'hF; wdata = 32'hFFFF_FFFF;
        model_reset();
        @(negedge clk);
        rst = 1'b0; req = 1'b0; we = 1'b0;
        for (int i = 0; i < 10; i++) access(0, 12'h800, 4'hF, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom % 6 == 0) io_sw = ($urandom % 2 == 0) ? 32'($urandom % 4) : $urandom;
            if ($urandom % 5 == 0) idle(1);
            else access(1'($urandom % 2), pick_addr(), 4'($urandom), $urandom);
        end
        idle(DB + 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
